// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// State encoding, next-pc select codes, NOP word and pc step.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    DISCARD
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_TGT
  } pc_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-pc mux: hold, pc+4 (wraps mod 2^32) or word-aligned target.
// Ports: pc_i, target_i, sel_i in; pc_next_o out.
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] target_i,
  input  pc_sel_e     sel_i,
  output logic [31:0] pc_next_o
);

  logic unused_tgt_bits;
  assign unused_tgt_bits = ^target_i[1:0];

  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_i)
      SEL_INC: pc_next_o = pc_i + PC_STEP;
      SEL_TGT: pc_next_o = {target_i[31:2], 2'b00};
      default: pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: pc, imem read/busywait handshake, one pc/instr to IF/ID.
// Ports: CLK/RESET, STALL, BRANCH_*, IMEM_*, PC_OUT, INSTRUCTION_OUT, BUSYWAIT_OUT.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] PC_OUT,
  output logic [31:0] INSTRUCTION_OUT,
  output logic        BUSYWAIT_OUT
);

  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_q, req_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  instr_q, instr_d;
  logic         rd_q, rd_d;
  logic         bsy_q, bsy_d;
  pc_sel_e      pc_sel;
  logic [31:0]  pc_next;

  pc_next_sel u_pc_next_sel (
    .pc_i      (pc_q),
    .target_i  (BRANCH_TARGET),
    .sel_i     (pc_sel),
    .pc_next_o (pc_next)
  );

  always_comb begin
    pc_sel = SEL_HOLD;
    unique case (state_q)
      VALID: begin
        if (BRANCH_TAKEN)
          pc_sel = SEL_TGT;
        else if (!STALL)
          pc_sel = SEL_INC;
      end
      default: begin
        if (BRANCH_TAKEN)
          pc_sel = SEL_TGT;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    pc_d     = pc_next;
    unique case (state_q)
      IDLE: begin
        req_d   = pc_next;
        state_d = FETCH;
      end
      FETCH: begin
        if (BRANCH_TAKEN) begin
          // busy: keep old address on the bus until it completes
          if (IMEM_BUSYWAIT)
            state_d = DISCARD;
          else
            req_d = pc_next;
        end else if (!IMEM_BUSYWAIT) begin
          instr_d  = IMEM_READDATA;
          pc_out_d = req_q;
          state_d  = VALID;
        end
      end
      VALID: begin
        if (BRANCH_TAKEN || !STALL) begin
          req_d   = pc_next;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (!BRANCH_TAKEN && !IMEM_BUSYWAIT) begin
          req_d   = pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_d  = (state_d == FETCH) || (state_d == DISCARD);
    bsy_d = (state_d != VALID);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      rd_q     <= 1'b0;
      bsy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      rd_q     <= rd_d;
      bsy_q    <= bsy_d;
    end
  end

  assign IMEM_READ       = rd_q;
  assign IMEM_ADDRESS    = req_q;
  assign PC_OUT          = pc_out_q;
  assign INSTRUCTION_OUT = instr_q;
  assign BUSYWAIT_OUT    = bsy_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed plan plus random
// stall/redirect/busywait checked against a cycle model.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] PC_OUT;
  logic [31:0] INSTRUCTION_OUT;
  logic        BUSYWAIT_OUT;

  int n_chk = 0;
  int n_fail = 0;

  localparam int M_IDLE = 0;
  localparam int M_FETCH = 1;
  localparam int M_VALID = 2;
  localparam int M_DISC = 3;

  int          m_st;
  logic [31:0] m_pc, m_req, m_pco, m_ins;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {a[15:0], ~a[15:0]} ^ a;
  endfunction

  assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

  instruction_fetch_unit dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .STALL           (STALL),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .IMEM_READDATA   (IMEM_READDATA),
    .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
    .IMEM_READ       (IMEM_READ),
    .IMEM_ADDRESS    (IMEM_ADDRESS),
    .PC_OUT          (PC_OUT),
    .INSTRUCTION_OUT (INSTRUCTION_OUT),
    .BUSYWAIT_OUT    (BUSYWAIT_OUT)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = M_IDLE;
    m_pc  = 32'h0;
    m_req = 32'h0;
    m_pco = 32'h0;
    m_ins = 32'h0000_0013;
  endtask

  task automatic check_all();
    logic rd;
    rd = (m_st == M_FETCH) || (m_st == M_DISC);
    check("imem_read", 32'(IMEM_READ), 32'(rd));
    check("busywait", 32'(BUSYWAIT_OUT), 32'(m_st != M_VALID));
    check("pc_out", PC_OUT, m_pco);
    check("instr", INSTRUCTION_OUT, m_ins);
    if (rd) check("imem_addr", IMEM_ADDRESS, m_req);
    if (m_st == M_VALID)
      check("instr_vs_mem", INSTRUCTION_OUT, mem_word(PC_OUT));
  endtask

  // Called just after a falling edge: drive, clock, update model, check.
  task automatic step(input logic s, input logic b,
                      input logic [31:0] t, input logic bw);
    logic [31:0] tg, rdat;
    STALL         = s;
    BRANCH_TAKEN  = b;
    BRANCH_TARGET = t;
    IMEM_BUSYWAIT = bw;
    @(posedge CLK);
    tg   = t & 32'hFFFF_FFFC;
    rdat = mem_word(m_req);
    case (m_st)
      M_IDLE: begin
        if (b) m_pc = tg;
        m_req = m_pc;
        m_st  = M_FETCH;
      end
      M_FETCH: begin
        if (b) begin
          m_pc = tg;
          if (bw) m_st = M_DISC;
          else    m_req = tg;
        end else if (!bw) begin
          m_ins = rdat;
          m_pco = m_req;
          m_st  = M_VALID;
        end
      end
      M_VALID: begin
        if (b) begin
          m_pc = tg; m_req = tg; m_st = M_FETCH;
        end else if (!s) begin
          m_pc = m_pc + 32'd4; m_req = m_pc; m_st = M_FETCH;
        end
      end
      default: begin
        if (b) m_pc = tg;
        else if (!bw) begin
          m_req = m_pc; m_st = M_FETCH;
        end
      end
    endcase
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_all();
    RESET = 1'b1;

    step(0, 0, 0, 0);
    check("first_req", IMEM_ADDRESS, 32'h0);
    step(0, 0, 0, 0);
    check("h0_pc", PC_OUT, 32'h0);
    check("h0_ins", INSTRUCTION_OUT, 32'h0050_0093);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check("wait_addr", IMEM_ADDRESS, 32'h4);
      check("wait_bsy", 32'(BUSYWAIT_OUT), 32'd1);
    end
    step(0, 0, 0, 0);
    check("h1_pc", PC_OUT, 32'h4);
    check("h1_ins", INSTRUCTION_OUT, 32'h00A0_0113);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("stall_pc", PC_OUT, 32'h4);
    check("stall_rd", 32'(IMEM_READ), 32'd0);
    step(0, 0, 0, 0);
    check("adv_addr", IMEM_ADDRESS, 32'h8);
    step(0, 1, 32'h40, 1);
    check("disc_addr", IMEM_ADDRESS, 32'h8);
    step(0, 0, 0, 1);
    check("disc_addr2", IMEM_ADDRESS, 32'h8);
    step(0, 0, 0, 0);
    check("redir_addr", IMEM_ADDRESS, 32'h40);
    step(0, 0, 0, 0);
    check("redir_pc", PC_OUT, 32'h40);
    step(0, 1, 32'h43, 0);
    check("align_addr", IMEM_ADDRESS, 32'h40);
    step(0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0);
    check("top_pc", PC_OUT, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_addr", IMEM_ADDRESS, 32'h0);

    step(0, 0, 0, 1);
    #2 RESET = 1'b0;
    #1;
    check("rst_rd", 32'(IMEM_READ), 32'd0);
    check("rst_bsy", 32'(BUSYWAIT_OUT), 32'd1);
    check("rst_pc", PC_OUT, 32'h0);
    check("rst_ins", INSTRUCTION_OUT, 32'h13);
    model_reset();
    @(negedge CLK);
    check_all();
    RESET = 1'b1;
    step(0, 0, 0, 1);
    check("post_rst_addr", IMEM_ADDRESS, 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom();
      if ($urandom_range(0, 3) == 0)
        t = 32'hFFFF_FFF0 | (t & 32'hF);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           t, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Producer side of the IF/ID interface. Holds the program counter, issues word reads to instruction memory under a read/busywait handshake, and presents one PC/instruction pair with a busywait flag to the IF/ID pipeline register. Honours hazard-unit stalls and squashes wrong-path fetches on branch/jump redirects.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0013: instruction word driven while nothing is valid (`addi x0,x0,0`).

- `CLK` in 1: single clock. All state changes on its rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `STALL` in 1: hazard-unit stall. Blocks handoff.
- `BRANCH_TAKEN` in 1: redirect request, sampled at the rising edge.
- `BRANCH_TARGET` in 32: redirect address. Bits [1:0] are ignored and forced to 0.
- `IMEM_READDATA` in 32: instruction word. Valid in a cycle with `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0.
- `IMEM_BUSYWAIT` in 1: memory not ready.
- `IMEM_READ` out 1: read request.
- `IMEM_ADDRESS` out 32: byte address, word-aligned.
- `PC_OUT` out 32: PC of the presented instruction. Drives IF/ID `IN_PC`.
- `INSTRUCTION_OUT` out 32: presented instruction. Drives IF/ID `IN_INSTRUCTION`.
- `BUSYWAIT_OUT` out 1: 1 when `PC_OUT`/`INSTRUCTION_OUT` are not valid. OR'd with `STALL` at top level into IF/ID `BUSYWAIT`.

## Operation

- Registers: `pc` (next fetch address), `req_addr` (address of the outstanding request), `PC_OUT`, `INSTRUCTION_OUT`, state.
- States: IDLE, FETCH, VALID, DISCARD.
- Reset (`RESET`=0, immediate):
  - state=IDLE, `pc`=`req_addr`=`PC_OUT`=`RESET_PC`.
  - `INSTRUCTION_OUT`=`NOP_INSTR`.
  - `BUSYWAIT_OUT`=1, `IMEM_READ`=0, `IMEM_ADDRESS`=`RESET_PC`.
- IDLE: on the first edge after reset release: `req_addr`<=`pc`, go to FETCH.
- FETCH:
  - Outputs: `IMEM_READ`=1, `IMEM_ADDRESS`=`req_addr`.
  - `IMEM_BUSYWAIT`=1: hold.
  - `IMEM_BUSYWAIT`=0 and no redirect: `INSTRUCTION_OUT`<=`IMEM_READDATA`, `PC_OUT`<=`req_addr`, go to VALID.
- VALID:
  - Outputs: `IMEM_READ`=0, `BUSYWAIT_OUT`=0.
  - Handoff is an edge with `STALL`=0: `pc`<=`pc`+4, `req_addr`<=`pc`+4, go to FETCH.
  - `STALL`=1: hold all outputs.
- DISCARD:
  - Outputs: `IMEM_READ`=1, `IMEM_ADDRESS`=`req_addr` (old address, kept stable for memory).
  - When `IMEM_BUSYWAIT`=0: drop the returned data, `req_addr`<=`pc`, go to FETCH.
- `BUSYWAIT_OUT`=1 in every state except VALID.
- Redirect (`BRANCH_TAKEN`=1 at an edge) has highest priority over handoff and data capture. Let T = {`BRANCH_TARGET`[31:2],2'b00}.
  - IDLE or VALID: `pc`<=T, `req_addr`<=T, go to FETCH. The VALID instruction is squashed even if `STALL`=0.
  - FETCH with `IMEM_BUSYWAIT`=0: data dropped, `pc`<=T, `req_addr`<=T, stay in FETCH.
  - FETCH with `IMEM_BUSYWAIT`=1: `pc`<=T, go to DISCARD.
  - DISCARD: `pc`<=T, stay in DISCARD (last target wins).
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Reset in any state, including with a memory request outstanding, returns to the reset values. Data returning after reset is ignored because `IMEM_READ`=0.

## Timing

- Zero-wait memory: IDLE→FETCH on edge 1, first instruction valid after edge 2. Steady throughput is one instruction per 2 cycles (FETCH, VALID).
- Each memory wait cycle adds one cycle. `IMEM_ADDRESS` is stable from request assertion until the edge where `IMEM_BUSYWAIT`=0.
- Redirect to first target instruction valid: 2 cycles with zero-wait memory, plus the remaining wait cycles of any request being discarded.
- `PC_OUT`/`INSTRUCTION_OUT` change only on edges that enter VALID, and on reset.
- No combinational path from `STALL` or `BRANCH_TAKEN` to any output.

## Structure

- Shared package `fetch_pkg`: state encoding, `NOP_INSTR` constant, `PC_STEP`=4.
- One sub-module, `pc_next_sel`: combinational next-`pc` mux selecting hold, `pc`+4, or aligned target.

## Test plan

- Reset mid-FETCH (`RESET`=0 with `IMEM_BUSYWAIT`=1) → same cycle: `IMEM_READ`=0, `BUSYWAIT_OUT`=1, `PC_OUT`=0, `INSTRUCTION_OUT`=32'h13. After release, the first request goes to 0x0.
- Zero-wait memory returning 32'h0050_0093@0x0, 32'h00A0_0113@0x4, `STALL`=0 → handoffs of (0x0, 0x00500093), then (0x4, 0x00A00113), then 0x8, one every 2 cycles.
- `IMEM_BUSYWAIT` held high 3 cycles on 0x4 → `IMEM_ADDRESS`=0x4 stable throughout, `BUSYWAIT_OUT`=1, VALID on the edge after busywait drops.
- `STALL`=1 for 2 cycles in VALID → outputs held, `IMEM_READ`=0, `pc` unchanged. Next handoff PC advances by exactly 4.
- Redirect to 0x40 while 0x8 is busy → DISCARD with `IMEM_ADDRESS`=0x8 until the data returns. 0x8 data never presented; next request at 0x40.
- Target 32'h0000_0043 → fetch at 0x40.
- `pc`=32'hFFFF_FFFC handoff → next fetch at 0x0.
